stopwatch_lap: RTL and testbench
================================

# stopwatch_lap

Parametrised multi-digit stopwatch with start/stop, lap (split) hold, clear and sticky overflow, driving a time-multiplexed common-anode seven-segment display. It is the next-generation replacement for the fixed 4-digit stopwatch. It sits between the debounced push-button conditioners and the board's display pins. The digit count, time base, scan rate and digit radix are all configurable.

## Interface
- NUM_DIGITS, 4: number of BCD digits and anodes, legal range 2..8.
- TICK_DIV, 5_000_000: clock cycles per least-significant count (0.1 s at 50 MHz); must be ≥2.
- REFRESH_DIV, 50_000: clock cycles each digit is lit during scan; must be ≥1.
- MIXED_RADIX, 1: 1 = time format, where the digit radices from digit 0 upward are 10,10,6,10,6,10,10,10; 0 = every digit is radix 10.

Ports:
- clock  in  1  system clock; all logic is on the rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- start  in  1  single-cycle pulse; toggles run/stop.
- lap  in  1  single-cycle pulse; latches the split.
- clear  in  1  single-cycle pulse; zeroes the count or releases the hold.
- a,b,c,d,e,f,g  out  1 each  segments, active-low, registered.
- dp  out  1  decimal point, active-low, registered.
- an  out  NUM_DIGITS  anodes, active-low, one-hot-low, registered.
- count_bcd  out  4*NUM_DIGITS  live count; digit i is at [4i+3:4i].
- running  out  1  high while counting.
- lap_active  out  1  high while the display shows the latched split.
- overflow  out  1  sticky; set on full-scale wrap.

## Operation
- All pulse inputs are evaluated against the pre-edge state. Input pulses are already synchronous and debounced.
- Run control:
  - A start pulse toggles running.
  - The prescaler advances only while running. It is held (not cleared) on stop, so a resumed run keeps fractional time.
- Prescaler and tick:
  - The prescaler counts 0..TICK_DIV-1.
  - A tick occurs on the edge where the prescaler equals TICK_DIV-1 while running. On that edge the prescaler returns to 0.
- Count update on a tick:
  - Digit 0 increments.
  - A digit at radix-1 wraps to 0 and carries into the next digit.
- Full-scale wrap: when every digit is at radix-1 and a tick occurs, the count becomes all zeros, overflow is set, and counting continues.
- Lap:
  - A lap pulse while running copies count_bcd into the lap register and sets lap_active.
  - A further lap pulse while running re-latches the split.
  - A lap pulse while stopped is ignored.
- Clear while stopped: zeroes the count, prescaler and lap register, and clears lap_active and overflow.
- Clear while running: only clears lap_active.
- Simultaneous events:
  - start + clear while stopped: the count is zeroed, then the stopwatch runs from 0.
  - start + clear while running: the stopwatch stops and the hold is released; the count is kept.
  - start + lap while running: the lap latches the pre-edge count, then the stopwatch stops.
  - A tick coinciding with a stop: the increment still occurs.
  - A tick coinciding with a lap: the latched value is the pre-increment count.
- Display source: the lap register when lap_active = 1, otherwise the live count.
- Scan:
  - The refresh counter counts 0..REFRESH_DIV-1.
  - On wrap, the digit index advances 0..NUM_DIGITS-1 and then returns to 0.
- Decode:
  - The digit at the current index is decoded to standard 0-9 segments (0 = lit).
  - Values 10-15 cannot occur.
- dp is lit only when the index is 1 (tenths separator), otherwise 1.

## Timing
- Reset values:
  - running, lap_active and overflow = 0.
  - count_bcd = 0; prescaler, refresh counter and index = 0.
  - an = all ones; a..g = 1; dp = 1.
- Display outputs:
  - Registered, with one cycle of latency from index/source to pins.
  - In the first cycle after reset release: an[0] = 0 and segments show "0" (a..f = 0, g = 1).
- Start latency: if start is sampled at edge E0, running = 1 after E0. The first increment is visible after edge E0+TICK_DIV. Subsequent increments follow every TICK_DIV cycles.
- Stop latency: running falls after the sampling edge; no further increments occur.
- Lap/clear latency: lap_active and count_bcd update after the sampling edge. The display reflects the change on the next scan slot of each digit, plus one cycle.
- Scan period: each anode is low for exactly REFRESH_DIV cycles. A full frame is NUM_DIGITS*REFRESH_DIV cycles.
- Reset asserted mid-run: all state returns to reset values immediately, with no clock required.

## Test plan
Bench parameters: TICK_DIV=4, REFRESH_DIV=2, NUM_DIGITS=4, MIXED_RADIX=1.
- Reset then one start pulse:
  - count_bcd = 16'h0001 exactly 4 cycles after the start edge.
  - count_bcd = 16'h0010 after 40 cycles.
- Run for 600 ticks (2400 cycles) → count_bcd = 16'h1000 (1:00.0). The 59.9 → 1:00.0 carry chain must be exact.
- Lap at count 0x0025 → lap_active = 1. The scanned digits show 0,0,2,5 while count_bcd keeps rising. A clear pulse then releases the hold and the display tracks live.
- Stop at 0x0123, wait 100 cycles → count unchanged. Restart → the next increment arrives within ≤4 cycles, with the prescaler preserved. Stop, then clear → count 0.
- MIXED_RADIX=1, preload by running to 9:59.9, then one tick → count 0, overflow = 1 and running stays 1. Clear while stopped → overflow = 0.
- Scan check:
  - an cycles 1110 → 1101 → 1011 → 0111, 2 cycles each.
  - dp = 0 only while an = 1101.
  - Asserting reset mid-scan → an = 1111 with no clock edge.

Source files
------------

// File: rtl/stopwatch_lap.sv
// Multi-digit BCD stopwatch with run/stop, lap hold, clear and sticky overflow.
// Drives a time-multiplexed common-anode seven-segment display with registered pins.
module stopwatch_lap #(
  parameter int NUM_DIGITS  = 4,
  parameter int TICK_DIV    = 5_000_000,
  parameter int REFRESH_DIV = 50_000,
  parameter int MIXED_RADIX = 1
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    start,
  input  logic                    lap,
  input  logic                    clear,
  output logic                    a,
  output logic                    b,
  output logic                    c,
  output logic                    d,
  output logic                    e,
  output logic                    f,
  output logic                    g,
  output logic                    dp,
  output logic [NUM_DIGITS-1:0]   an,
  output logic [4*NUM_DIGITS-1:0] count_bcd,
  output logic                    running,
  output logic                    lap_active,
  output logic                    overflow
);

  localparam int PW = $clog2(TICK_DIV);
  localparam int RW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int IW = $clog2(NUM_DIGITS);
  localparam int CW = 4 * NUM_DIGITS;

  logic [PW-1:0]         prescaler;
  logic [RW-1:0]         refresh;
  logic [IW-1:0]         index;
  logic [CW-1:0]         lap_count;
  logic [CW-1:0]         next_count;
  logic [CW-1:0]         source;
  logic [NUM_DIGITS:0]   carry;
  logic                  tick;
  logic [3:0]            digit;
  logic [6:0]            seg_next;
  logic [NUM_DIGITS-1:0] an_next;

  assign tick     = running && (prescaler == PW'(TICK_DIV - 1));
  assign carry[0] = tick;

  // Ripple carry through the digits; the carry out of the top digit marks full-scale wrap.
  generate
    for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
      localparam logic [3:0] DMAX = (MIXED_RADIX != 0 && (gi == 2 || gi == 4)) ? 4'd5 : 4'd9;
      logic at_max;
      assign at_max         = (count_bcd[4*gi +: 4] == DMAX);
      assign carry[gi+1]    = carry[gi] && at_max;
      assign next_count[4*gi +: 4] = !carry[gi] ? count_bcd[4*gi +: 4] :
                                     (at_max ? 4'd0 : count_bcd[4*gi +: 4] + 4'd1);
    end
  endgenerate

  assign source = lap_active ? lap_count : count_bcd;

  always_comb begin
    digit          = source[{index, 2'b00} +: 4];
    an_next        = '1;
    an_next[index] = 1'b0;
    case (digit)
      4'd0:    seg_next = 7'b0000001;
      4'd1:    seg_next = 7'b1001111;
      4'd2:    seg_next = 7'b0010010;
      4'd3:    seg_next = 7'b0000110;
      4'd4:    seg_next = 7'b1001100;
      4'd5:    seg_next = 7'b0100100;
      4'd6:    seg_next = 7'b0100000;
      4'd7:    seg_next = 7'b0001111;
      4'd8:    seg_next = 7'b0000000;
      4'd9:    seg_next = 7'b0000100;
      default: seg_next = 7'b1111111;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      running    <= 1'b0;
      lap_active <= 1'b0;
      overflow   <= 1'b0;
      count_bcd  <= '0;
      lap_count  <= '0;
      prescaler  <= '0;
      refresh    <= '0;
      index      <= '0;
      an         <= '1;
      {a, b, c, d, e, f, g} <= 7'b1111111;
      dp         <= 1'b1;
    end else begin
      running <= running ^ start;

      if (!running && clear) begin
        count_bcd <= '0;
        prescaler <= '0;
        lap_count <= '0;
        overflow  <= 1'b0;
      end else begin
        count_bcd <= next_count;
        if (running) prescaler <= tick ? '0 : prescaler + PW'(1);
        if (carry[NUM_DIGITS]) overflow <= 1'b1;
      end

      if (running && lap) begin
        lap_count  <= count_bcd;
        lap_active <= 1'b1;
      end
      if (clear) lap_active <= 1'b0;

      if (refresh == RW'(REFRESH_DIV - 1)) begin
        refresh <= '0;
        index   <= (index == IW'(NUM_DIGITS - 1)) ? '0 : index + IW'(1);
      end else begin
        refresh <= refresh + RW'(1);
      end

      an                    <= an_next;
      {a, b, c, d, e, f, g} <= seg_next;
      dp                    <= (index != IW'(1));
    end
  end

endmodule

// File: tb/tb_stopwatch_lap.sv
// Randomized and directed bench for stopwatch_lap against a tick-count reference model.
// The model tracks elapsed ticks as an integer and converts to mixed-radix BCD arithmetically.
module tb_stopwatch_lap;

  localparam int ND   = 4;
  localparam int TD   = 4;
  localparam int RD   = 2;
  localparam int FULL = 6000;
  localparam logic [6:0] SEG [0:9] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                                       7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
                                       7'b0000000, 7'b0000100};

  logic clock = 1'b0;
  logic reset = 1'b0;
  logic start = 1'b0;
  logic lap   = 1'b0;
  logic clear = 1'b0;
  logic a, b, c, d, e, f, g, dp;
  logic [ND-1:0]   an;
  logic [4*ND-1:0] count_bcd;
  logic running, lap_active, overflow;

  stopwatch_lap #(
    .NUM_DIGITS(ND), .TICK_DIV(TD), .REFRESH_DIV(RD), .MIXED_RADIX(1)
  ) dut (
    .clock(clock), .reset(reset), .start(start), .lap(lap), .clear(clear),
    .a(a), .b(b), .c(c), .d(d), .e(e), .f(f), .g(g), .dp(dp), .an(an),
    .count_bcd(count_bcd), .running(running), .lap_active(lap_active), .overflow(overflow)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state: run flag, prescaler, elapsed ticks, lap ticks, flags, edges since reset.
  bit m_run, m_la, m_ov;
  int m_p, m_t, m_lv, m_e;

  function automatic logic [15:0] to_bcd(input int v);
    logic [15:0] res;
    int r;
    int rem;
    rem = v;
    for (int i = 0; i < ND; i++) begin
      r = (i == 2) ? 6 : 10;
      res[4*i +: 4] = 4'(rem % r);
      rem = rem / r;
    end
    return res;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic step(input bit s, input bit l, input bit cl);
    logic [15:0] src;
    logic [3:0]  exp_an;
    logic [6:0]  exp_seg;
    logic        exp_dp;
    int idx;
    bit tk;
    int nt, np, nlv;
    bit nla, nov;
    idx     = (m_e / RD) % ND;
    src     = to_bcd(m_la ? m_lv : m_t);
    exp_an  = 4'hF;
    exp_an[idx] = 1'b0;
    exp_seg = SEG[src[4*idx +: 4]];
    exp_dp  = (idx != 1);

    tk  = m_run && (m_p == TD - 1);
    nt  = m_t;
    nov = m_ov;
    if (tk) begin
      nt = m_t + 1;
      if (nt == FULL) begin
        nt  = 0;
        nov = 1;
      end
    end
    np  = m_run ? (tk ? 0 : m_p + 1) : m_p;
    nlv = m_lv;
    nla = m_la;
    if (m_run && l) begin
      nlv = m_t;
      nla = 1;
    end
    if (cl) nla = 0;
    if (!m_run && cl) begin
      nt = 0; np = 0; nlv = 0; nov = 0;
    end
    m_run = m_run ^ s;
    m_t = nt; m_p = np; m_lv = nlv; m_la = nla; m_ov = nov;
    m_e++;

    start = s; lap = l; clear = cl;
    @(posedge clock);
    #1;
    start = 0; lap = 0; clear = 0;
    check("count", 32'(count_bcd), 32'(to_bcd(m_t)));
    check("running", 32'(running), 32'(m_run));
    check("lap_active", 32'(lap_active), 32'(m_la));
    check("overflow", 32'(overflow), 32'(m_ov));
    check("an", 32'(an), 32'(exp_an));
    check("seg", 32'({a, b, c, d, e, f, g}), 32'(exp_seg));
    check("dp", 32'(dp), 32'(exp_dp));
  endtask

  task automatic do_reset(input bit mid);
    if (mid) #2;
    reset = 1'b1;
    #1;
    check("rst_an", 32'(an), 32'hF);
    check("rst_seg", 32'({a, b, c, d, e, f, g}), 32'h7F);
    check("rst_dp", 32'(dp), 32'h1);
    check("rst_count", 32'(count_bcd), 32'h0);
    check("rst_flags", 32'({running, lap_active, overflow}), 32'h0);
    @(posedge clock);
    #1;
    reset = 1'b0;
    m_run = 0; m_la = 0; m_ov = 0; m_p = 0; m_t = 0; m_lv = 0; m_e = 0;
  endtask

  task automatic run_until(input int target, input int budget);
    int n;
    n = 0;
    while (m_t != target && n < budget) begin
      step(0, 0, 0);
      n++;
    end
    check("reach_target", 32'(count_bcd), 32'(to_bcd(target)));
  endtask

  initial begin
    logic [3:0] scan_an [0:7];
    int n;
    bit s, l, cl;
    scan_an = '{4'hE, 4'hE, 4'hD, 4'hD, 4'hB, 4'hB, 4'h7, 4'h7};

    #1;
    do_reset(0);
    $display("txn: start and first increments");
    step(1, 0, 0);
    repeat (3) step(0, 0, 0);
    check("first_tick_early", 32'(count_bcd), 32'h0000);
    step(0, 0, 0);
    check("first_tick", 32'(count_bcd), 32'h0001);
    repeat (36) step(0, 0, 0);
    check("forty_cycles", 32'(count_bcd), 32'h0010);
    repeat (2360) step(0, 0, 0);
    check("one_minute", 32'(count_bcd), 32'h1000);

    $display("txn: lap hold at 0x0025 then release");
    do_reset(0);
    step(1, 0, 0);
    run_until(25, 200);
    step(0, 1, 0);
    check("lap_set", 32'(lap_active), 32'h1);
    repeat (16) step(0, 0, 0);
    check("live_moves_under_hold", 32'(count_bcd > 16'h0025), 32'h1);
    step(0, 0, 1);
    check("lap_release", 32'(lap_active), 32'h0);
    repeat (8) step(0, 0, 0);

    $display("txn: stop at 0x0123, hold, resume, stop and clear");
    run_until(123, 1000);
    step(1, 0, 0);
    repeat (100) step(0, 0, 0);
    check("stopped_hold", 32'(count_bcd), 32'h0123);
    step(1, 0, 0);
    n = 0;
    while (count_bcd == 16'h0123 && n < 4) begin
      step(0, 0, 0);
      n++;
    end
    check("resume_latency", 32'(count_bcd), 32'h0124);
    step(1, 0, 0);
    step(0, 0, 1);
    check("clear_stopped", 32'(count_bcd), 32'h0000);

    $display("txn: full-scale wrap from 9:59.9");
    do_reset(0);
    step(1, 0, 0);
    run_until(5999, 30000);
    check("full_scale", 32'(count_bcd), 32'h9599);
    run_until(0, 10);
    check("wrap_overflow", 32'(overflow), 32'h1);
    check("wrap_running", 32'(running), 32'h1);
    step(1, 0, 0);
    step(0, 0, 1);
    check("overflow_cleared", 32'(overflow), 32'h0);

    $display("txn: scan order and mid-scan reset");
    do_reset(0);
    for (int k = 0; k < 8; k++) begin
      step(0, 0, 0);
      check("scan_an", 32'(an), 32'(scan_an[k]));
      check("scan_dp", 32'(dp), 32'(scan_an[k] != 4'hD));
    end
    repeat (3) step(0, 0, 0);
    do_reset(1);

    $display("txn: randomized pulses");
    for (int k = 0; k < 3000; k++) begin
      s  = ($urandom % 40) == 0;
      l  = ($urandom % 25) == 0;
      cl = ($urandom % 60) == 0;
      if (l && cl) l = 0;
      step(s, l, cl);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
